// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit holding architectural HI/LO.
// Define MDU_DIVZERO_HOLD_EN to leave HI/LO untouched on a divide by zero.
module muldiv_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  mdop,
  input  logic        valid,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] phi_q, phi_d;
  logic [31:0] plo_q, plo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic signed [63:0] as_w, bs_w, prod_s;
  logic [63:0] prod_u;
  logic [31:0] bds, bdu;
  logic [31:0] quo_s, rem_s, quo_u, rem_u;
  logic [31:0] res_hi, res_lo;
  logic        ovf, is_div;

  always_comb begin
    as_w   = {{32{a[31]}}, a};
    bs_w   = {{32{b[31]}}, b};
    prod_s = as_w * bs_w;
    prod_u = {32'd0, a} * {32'd0, b};
    // Dividing by 1 yields exactly the required 0x80000000 / -1 result.
    ovf    = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    bds    = (b == 32'd0 || ovf) ? 32'd1 : b;
    bdu    = (b == 32'd0) ? 32'd1 : b;
    quo_s  = $signed(a) / $signed(bds);
    rem_s  = $signed(a) % $signed(bds);
    quo_u  = a / bdu;
    rem_u  = a % bdu;
    is_div = (mdop == OP_DIV) || (mdop == OP_DIVU);
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (mdop)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        res_hi = rem_s;
        res_lo = quo_s;
      end
      OP_DIVU: begin
        res_hi = rem_u;
        res_lo = quo_u;
      end
      default: ;
    endcase
    if (is_div && b == 32'd0) begin
`ifdef MDU_DIVZERO_HOLD_EN
      res_hi = hi_q;
      res_lo = lo_q;
`else
      res_hi = a;
      res_lo = 32'hFFFF_FFFF;
`endif
    end
  end

  assign busy  = (state_q == RUN);
  assign start = valid && (mdop >= OP_MULT) && (mdop <= OP_DIVU) && !busy;
  assign hi    = hi_q;
  assign lo    = lo_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          phi_d   = res_hi;
          plo_d   = res_lo;
          cnt_d   = (mdop <= OP_MULTU) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
          state_d = RUN;
        end else if (valid && mdop == OP_MTHI) begin
          hi_d = a;
        end else if (valid && mdop == OP_MTLO) begin
          lo_d = a;
        end
      end
      RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d    = phi_q;
          lo_d    = plo_q;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: random + directed stimulus against an arithmetic HI/LO model.
// Honours MDU_DIVZERO_HOLD_EN the same way the design does.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  mdop;
  logic        valid;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  localparam int MC = 5;
  localparam int DC = 10;

  muldiv_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .mdop(mdop),
    .valid(valid), .start(start), .busy(busy), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit run_chk = 1'b0;

  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  int          m_rem;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void ref_calc(input logic [2:0] op,
                                   input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] rh,
                                   output logic [31:0] rl);
    longint p;
    longint unsigned ux, uy, q, r;
    rh = 32'd0;
    rl = 32'd0;
    if (op == 3'd1) begin
      p = longint'($signed(x)) * longint'($signed(y));
      {rh, rl} = p;
    end else if (op == 3'd2) begin
      ux = {32'd0, x};
      uy = {32'd0, y};
      q = ux * uy;
      {rh, rl} = q;
    end else if (y == 32'd0) begin
`ifdef MDU_DIVZERO_HOLD_EN
      rh = m_hi;
      rl = m_lo;
`else
      rh = x;
      rl = 32'hFFFF_FFFF;
`endif
    end else if (op == 3'd3) begin
      ux = {32'd0, (x[31] ? (~x + 32'd1) : x)};
      uy = {32'd0, (y[31] ? (~y + 32'd1) : y)};
      q = ux / uy;
      r = ux - q * uy;
      if (x[31] ^ y[31]) q = -q;
      if (x[31]) r = -r;
      rl = q[31:0];
      rh = r[31:0];
    end else begin
      ux = {32'd0, x};
      uy = {32'd0, y};
      q = ux / uy;
      r = ux % uy;
      rl = q[31:0];
      rh = r[31:0];
    end
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_rem = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (valid) begin
      if (mdop >= 3'd1 && mdop <= 3'd4) begin
        ref_calc(mdop, a, b, m_phi, m_plo);
        m_rem = (mdop <= 3'd2) ? MC : DC;
      end else if (mdop == 3'd5) begin
        m_hi = a;
      end else if (mdop == 3'd6) begin
        m_lo = a;
      end
    end
  end

  always @(negedge clk) begin
    if (run_chk && !reset) begin
      chk("busy", 32'(busy), 32'(m_rem > 0));
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  task automatic step(input logic v, input logic [2:0] op,
                      input logic [31:0] x, input logic [31:0] y);
    valid = v; mdop = op; a = x; b = y;
    #1;
    chk("start", 32'(start),
        32'(v && op >= 3'd1 && op <= 3'd4 && m_rem == 0));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] x,
                        input logic [31:0] y, input int n);
    step(1'b1, op, x, y);
    for (int i = 1; i <= n; i++) begin
      chk("busy_lit", 32'(busy), 32'd1);
      step(1'b0, 3'd0, 32'd0, 32'd0);
    end
    chk("busy_done", 32'(busy), 32'd0);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 20) begin
      step(1'b0, 3'd0, 32'd0, 32'd0);
      k++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; valid = 1'b1; mdop = 3'd3; a = 32'd9; b = 32'd2;
    #1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(start), 32'd1);
    valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_chk = 1'b1;

    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, MC);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    run_op(3'd2, 32'hFFFF_FFFE, 32'd3, MC);
    chk("multu_hi", hi, 32'h0000_0002);
    chk("multu_lo", lo, 32'hFFFF_FFFA);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, DC);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    run_op(3'd4, 32'd7, 32'd2, DC);
    chk("divu_hi", hi, 32'd1);
    chk("divu_lo", lo, 32'd3);
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, DC);
    chk("ovf_hi", hi, 32'd0);
    chk("ovf_lo", lo, 32'h8000_0000);

    step(1'b1, 3'd5, 32'h1234_5678, 32'd0);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_busy", 32'(busy), 32'd0);
    step(1'b1, 3'd6, 32'h9ABC_DEF0, 32'd0);
    chk("mtlo_lo", lo, 32'h9ABC_DEF0);
    chk("mtlo_busy", 32'(busy), 32'd0);

    step(1'b1, 3'd1, 32'd3, 32'd4);
    step(1'b0, 3'd0, 32'd0, 32'd0);
    step(1'b1, 3'd6, 32'hDEAD_BEEF, 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 32'd0, 32'd0);
    chk("mul34_hi", hi, 32'd0);
    chk("mul34_lo", lo, 32'd12);

    run_op(3'd3, 32'd5, 32'd0, DC);
`ifdef MDU_DIVZERO_HOLD_EN
    chk("dz_hi", hi, 32'd0);
    chk("dz_lo", lo, 32'd12);
`else
    chk("dz_hi", hi, 32'd5);
    chk("dz_lo", lo, 32'hFFFF_FFFF);
`endif

    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
           pick(), pick());
    end
    wait_idle();

    step(1'b1, 3'd5, 32'hA5A5_A5A5, 32'd0);
    step(1'b1, 3'd3, 32'd100, 32'd7);
    step(1'b0, 3'd0, 32'd0, 32'd0);
    step(1'b0, 3'd0, 32'd0, 32'd0);
    valid = 1'b0; mdop = 3'd1; reset = 1'b1;
    #1;
    chk("mrst_hi", hi, 32'd0);
    chk("mrst_lo", lo, 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_start", 32'(start), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) step(1'b0, 3'd0, 32'd0, 32'd0);
    chk("post_hi", hi, 32'd0);
    chk("post_lo", lo, 32'd0);
    chk("post_busy", 32'(busy), 32'd0);

    run_chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
